pmem_responder: RTL



---
 rtl/pmem_types_pkg.sv | 22 ++
 rtl/pmem_responder_if.sv | 26 ++
 rtl/pmem_line_array.sv | 23 ++
 rtl/pmem_responder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pmem_types_pkg.sv
// Shared types and default geometry for the pmem_responder line-memory model.
package pmem_types_pkg;

    localparam int PMEM_LINE_W     = 256;
    localparam int PMEM_OFFSET_W   = 5;
    localparam int PMEM_DEPTH_BITS = 8;
    localparam int PMEM_LATENCY    = 4;

    typedef logic [PMEM_LINE_W-1:0] pmem_line_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } pmem_state_e;

    typedef enum logic {
        PMEM_OP_READ  = 1'b0,
        PMEM_OP_WRITE = 1'b1
    } pmem_op_e;

endpackage

// File: rtl/pmem_responder_if.sv
// Line-granular pmem request/response bus between the L2 cache (master) and memory (slave).
interface pmem_responder_if
    import pmem_types_pkg::*;
#(
    parameter int s_line = PMEM_LINE_W
) ();

    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [s_line-1:0] pmem_wdata;
    logic [s_line-1:0] pmem_rdata;
    logic              pmem_resp;
    logic              protocol_err;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp, protocol_err
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp, protocol_err
    );

endinterface

// File: rtl/pmem_line_array.sv
// Single-port line store with registered read data; no reset so it maps onto block RAM.
module pmem_line_array #(
    parameter int s_line       = 256,
    parameter int s_depth_bits = 8
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [s_depth_bits-1:0] index,
    input  logic [s_line-1:0]       wdata,
    output logic [s_line-1:0]       rdata
);

    logic [s_line-1:0] mem_q [2**s_depth_bits];

    // Read-first port: rdata always reflects the addressed line before this edge's write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[index] <= wdata;
        end
        rdata <= mem_q[index];
    end

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency line memory responder behind the L2 pmem bus.
// Optional PMEM_PROTOCOL_CHECK_EN builds a sticky protocol_err checker.
module pmem_responder
    import pmem_types_pkg::*;
#(
    parameter int s_offset     = 5,
    parameter int s_line       = 8 * (2**s_offset),
    parameter int s_depth_bits = 8,
    parameter int LATENCY      = 4
) (
    input  logic           clk,
    input  logic           rst,
    pmem_responder_if.slave bus
);

    localparam logic [7:0] CNT_INIT = 8'((LATENCY > 1) ? (LATENCY - 2) : 0);

    pmem_state_e             state_q;
    logic [7:0]              cnt_q;
    pmem_op_e                op_q;
    logic [s_depth_bits-1:0] idx_q;
    logic [s_line-1:0]       wdata_q;
    logic                    resp_q;
    logic [s_line-1:0]       rdata_hold_q;

    logic                    req_s;
    logic                    arr_we_s;
    logic [s_depth_bits-1:0] arr_idx_s;
    logic [s_line-1:0]       arr_wdata_s;
    logic [s_line-1:0]       arr_rdata_s;

    assign req_s = bus.pmem_read | bus.pmem_write;

    // With LATENCY==1 the commit edge is the accept edge, so IDLE steers the live request into the array.
    always_comb begin
        arr_idx_s   = idx_q;
        arr_wdata_s = wdata_q;
        arr_we_s    = 1'b0;
        if (state_q == IDLE) begin
            arr_idx_s   = bus.pmem_address[s_offset +: s_depth_bits];
            arr_wdata_s = bus.pmem_wdata;
            arr_we_s    = !rst && (LATENCY == 1) && bus.pmem_write;
        end else if (state_q == BUSY) begin
            arr_we_s    = !rst && (cnt_q == 8'd0) && (op_q == PMEM_OP_WRITE);
        end else begin
            arr_we_s    = 1'b0;
        end
    end

    pmem_line_array #(
        .s_line       (s_line),
        .s_depth_bits (s_depth_bits)
    ) u_array (
        .clk   (clk),
        .we    (arr_we_s),
        .index (arr_idx_s),
        .wdata (arr_wdata_s),
        .rdata (arr_rdata_s)
    );

    // Request FSM: latch in IDLE, count down in BUSY, pulse in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            op_q         <= PMEM_OP_READ;
            idx_q        <= '0;
            wdata_q      <= '0;
            resp_q       <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    resp_q <= 1'b0;
                    if (req_s) begin
                        idx_q   <= bus.pmem_address[s_offset +: s_depth_bits];
                        op_q    <= bus.pmem_write ? PMEM_OP_WRITE : PMEM_OP_READ;
                        wdata_q <= bus.pmem_wdata;
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                            resp_q  <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= RESP;
                        resp_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    resp_q  <= 1'b0;
                    if (op_q == PMEM_OP_READ) begin
                        rdata_hold_q <= arr_rdata_s;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    resp_q  <= 1'b0;
                end
            endcase
        end
    end

    // Array output is live only in a read's RESP cycle; otherwise the last read line is held.
    assign bus.pmem_resp  = resp_q;
    assign bus.pmem_rdata = (resp_q && (op_q == PMEM_OP_READ)) ? arr_rdata_s : rdata_hold_q;

`ifdef PMEM_PROTOCOL_CHECK_EN
    logic [31:0] chk_addr_q;
    logic        chk_rd_q;
    logic        chk_wr_q;
    logic        err_q;
    logic        viol_s;

    // A held request must stay identical until the response; simultaneous read+write is illegal.
    always_comb begin
        viol_s = 1'b0;
        if (state_q == IDLE) begin
            viol_s = bus.pmem_read && bus.pmem_write;
        end else if ((state_q == BUSY) || (state_q == RESP)) begin
            viol_s = (bus.pmem_read != chk_rd_q) || (bus.pmem_write != chk_wr_q) ||
                     (bus.pmem_address != chk_addr_q);
        end else begin
            viol_s = 1'b0;
        end
    end

    // Shadow of the accepted request plus the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_addr_q <= 32'd0;
            chk_rd_q   <= 1'b0;
            chk_wr_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if ((state_q == IDLE) && req_s) begin
                chk_addr_q <= bus.pmem_address;
                chk_rd_q   <= bus.pmem_read;
                chk_wr_q   <= bus.pmem_write;
            end
            if (viol_s) begin
                err_q <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    // Report the first violation after reset.
    always_ff @(posedge clk) begin
        if (!rst && viol_s && !err_q) begin
            $error("pmem_responder: protocol violation in state %s", state_q.name());
        end
    end
`endif

    assign bus.protocol_err = err_q;
`else
    logic unused_addr_s;
    assign unused_addr_s    = ^bus.pmem_address;
    assign bus.protocol_err = 1'b0;
`endif

endmodule
